// File: rtl/baud_ctrl_pkg.sv
// baud_ctrl_pkg: shared FSM encoding and timebase constants for the baud controller
package baud_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int OSR = 16;
  localparam int RESET_DIV = 326;
  localparam int DIV_MIN = 2;
endpackage

// File: rtl/baud_div_counter.sv
// baud_div_counter: clearable counter wrapping at limit-1 and pulsing tick on the wrap cycle
module baud_div_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = !clear && cnt == limit - DIV_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/baud_ctrl.sv
// baud_ctrl: oversample/bit baud timebase with run/stop FSM and bit-aligned divisor reload
module baud_ctrl #(
  parameter int DIV_W = 16,
  parameter int RESET_DIV = baud_ctrl_pkg::RESET_DIV,
  parameter int OSR = baud_ctrl_pkg::OSR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick_os,
  output logic             tick_bit,
  output logic             running
);
  import baud_ctrl_pkg::state_t;
  import baud_ctrl_pkg::IDLE;
  import baud_ctrl_pkg::RUN;
  import baud_ctrl_pkg::STOP;
  import baud_ctrl_pkg::DIV_MIN;
  localparam int OS_W = OSR > 1 ? $clog2(OSR) : 1;
  state_t state, state_n;
  logic [OS_W-1:0] os_cnt;
  logic [DIV_W-1:0] div_active, pend_div;
  logic pend_valid, accept, div_ok;
  assign cfg_ready = !pend_valid;
  assign accept = cfg_valid && cfg_ready;
  assign div_ok = cfg_div >= DIV_W'(DIV_MIN);
  assign running = state != IDLE;
  assign tick_bit = tick_os && os_cnt == OS_W'(OSR - 1);
  baud_div_counter #(.DIV_W(DIV_W)) u_div (
    .clk(clk),
    .reset(reset),
    .clear(!running),
    .limit(div_active),
    .tick(tick_os)
  );
  always_comb
    state_n = (state == IDLE) ? (enable ? RUN : IDLE)
            : (state == RUN)  ? (enable ? RUN : STOP)
            : (enable ? RUN : tick_bit ? IDLE : STOP);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // the bit boundary wraps os_cnt, so entering IDLE leaves it cleared
  always_ff @(posedge clk or posedge reset)
    if (reset) os_cnt <= '0;
    else if (!running) os_cnt <= '0;
    else if (tick_os) os_cnt <= tick_bit ? '0 : os_cnt + OS_W'(1);
  // divisor changes while running only land on a bit boundary, when the divider wraps to 0
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div_active <= DIV_W'(RESET_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= accept && !div_ok;
      if (accept && div_ok && (!running || tick_bit)) div_active <= cfg_div;
      else if (tick_bit && pend_valid) div_active <= pend_div;
      if (accept && div_ok && running && !tick_bit) begin
        pend_valid <= 1'b1;
        pend_div   <= cfg_div;
      end else if (tick_bit) pend_valid <= 1'b0;
    end
endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the divisor.
REQ-002 SHALL have parameter RESET_DIV, default 326, divisor loaded at reset (50 MHz / (16 x 9600)).
REQ-003 SHALL have parameter OSR, default 16, oversample ticks per bit.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  request to run the baud timebase.
REQ-007 SHALL have port cfg_div  input  DIV_W  new clocks-per-oversample-tick divisor.
REQ-008 SHALL have port cfg_valid  input  1  cfg_div offered.
REQ-009 SHALL have port cfg_ready  output  1  controller can accept cfg_div.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse: rejected divisor.
REQ-011 SHALL have port tick_os  output  1  one-cycle oversample tick.
REQ-012 SHALL have port tick_bit  output  1  one-cycle bit-boundary tick.
REQ-013 SHALL have port running  output  1  high in RUN or STOP.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, STOP.
REQ-015 In IDLE: SHALL hold the divider counter (div_cnt) and the oversample counter (os_cnt) at 0 and emit no ticks. enable=1 SHALL move the FSM to RUN on the next edge.
REQ-016 In RUN/STOP: div_cnt SHALL count 0..div_active-1 and wrap. tick_os SHALL be high exactly in the cycle where div_cnt==div_active-1.
REQ-017 The first tick_os SHALL occur in the div_active-th cycle of RUN, counting the first RUN cycle as 1.
REQ-018 os_cnt SHALL advance on each tick_os and wrap from OSR-1 to 0. tick_bit SHALL coincide with the tick_os on which os_cnt==OSR-1.
REQ-019 enable=0 in RUN SHALL move the FSM to STOP. Ticks SHALL continue until the next tick_bit, after which the FSM SHALL enter IDLE and clear both counters.
REQ-020 enable=1 in STOP SHALL return the FSM to RUN with no counter reset and no tick gap.
REQ-021 A divisor SHALL be accepted in the cycle where cfg_valid&cfg_ready.
REQ-022 A divisor accepted in IDLE SHALL become div_active on the next edge.
REQ-023 A divisor accepted in RUN/STOP SHALL be held pending and loaded into div_active on the edge that ends a tick_bit cycle. div_cnt SHALL restart at 0 with the new value.
REQ-024 A divisor accepted in the same cycle as tick_bit SHALL take effect at that boundary.
REQ-025 cfg_ready SHALL be low while a pending divisor exists and high otherwise.
REQ-026 An accepted cfg_div < 2 SHALL be discarded, with no pending value created. cfg_err SHALL pulse one cycle on the following cycle.
REQ-027 A divisor change SHALL never shorten or stretch a bit already in progress.
REQ-028 If the FSM enters IDLE with a divisor pending, that divisor SHALL be applied on the same edge.
REQ-029 Counter arithmetic SHALL be unsigned DIV_W bits with no overflow, given div_active >= 2.

Reset
REQ-030 reset SHALL force: state=IDLE, div_cnt=0, os_cnt=0, pending cleared, div_active=RESET_DIV.
REQ-031 reset SHALL force outputs: tick_os=0, tick_bit=0, cfg_err=0, running=0, cfg_ready=1.
REQ-032 reset asserted mid-operation SHALL discard any pending divisor and any partial bit, with no tick emitted.

Structure
REQ-033 A shared package baud_ctrl_pkg SHALL hold the FSM state encoding, OSR, RESET_DIV and DIV_MIN=2.
REQ-034 The divider SHALL be one sub-module, baud_div_counter: a reloadable counter with a clear input that emits the tick_os pulse. The FSM, os_cnt and config handshake SHALL stay in baud_ctrl.

Verification
REQ-035 Reset, then enable=1 with the default divisor -> first tick_os at RUN cycle 326; tick_os period 326 cycles; tick_bit period 5216 cycles.
REQ-036 In IDLE, write cfg_div=4, then enable=1 -> tick_os every 4 cycles; tick_bit every 64 cycles.
REQ-037 In RUN with div=4, write cfg_div=8 at os_cnt=5 -> cfg_ready low until the bit boundary; the current bit ends 64 cycles after its start; the next bit lasts 128 cycles; cfg_ready returns high.
REQ-038 Write cfg_div=1 -> handshake completes; cfg_err pulses once on the next cycle; period is unchanged.
REQ-039 Drop enable at os_cnt=3 -> ticks continue to tick_bit; running=0 on the cycle after. Re-raise enable at os_cnt=10 while in STOP -> no gap and no IDLE entry.
REQ-040 Assert reset mid-RUN with a divisor pending -> all outputs are at reset values and cfg_ready=1. After release with enable=1, the period is 326.
